// File: rtl/fma16_issue_ctrl.sv
`timescale 1ns/1ps
// fma16_issue_ctrl
// ----------------
// Shares one combinational fma16 datapath between NREQ requesters.
// A round-robin arbiter picks a requester while idle, the granted operands
// and controls are registered onto fma_* and held for LAT cycles, and then
// the fma16 result and flags are captured and offered on the rsp_* handshake
// together with the owning requester index.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester request handshake (ready is one-hot or zero)
//   req_x/y/z, req_ctrl   packed per-requester operands; ctrl = {mul, add, negp, negz, rm[1:0]}
//   fma_*                 registered operands/controls driven to the fma16 unit
//   fma_result/fma_flags  combinational result of the fma16 unit
//   rsp_valid/rsp_ready   response handshake; rsp_id/rsp_result/rsp_flags payload
//   fflags, clear_flags   sticky OR of accepted response flags, synchronous clear
//   busy                  controller is not idle
//   op_count              completed operations, wraps at 16 bits
module fma16_issue_ctrl #(
  parameter int NREQ = 2,
  parameter int LAT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [16*NREQ-1:0]   req_y,
  input  logic [16*NREQ-1:0]   req_z,
  input  logic [6*NREQ-1:0]    req_ctrl,
  output logic [15:0]          fma_x,
  output logic [15:0]          fma_y,
  output logic [15:0]          fma_z,
  output logic                 fma_mul,
  output logic                 fma_add,
  output logic                 fma_negp,
  output logic                 fma_negz,
  output logic [1:0]           fma_roundmode,
  input  logic [15:0]          fma_result,
  input  logic [3:0]           fma_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [15:0]          rsp_result,
  output logic [3:0]           rsp_flags,
  output logic [3:0]           fflags,
  input  logic                 clear_flags,
  output logic                 busy,
  output logic [15:0]          op_count
);

  // Counter only needs to hold LAT-1.
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [1:0]    rr_ptr;

  logic          grant_found;
  logic [1:0]    grant_idx;
  logic [15:0]   sel_x;
  logic [15:0]   sel_y;
  logic [15:0]   sel_z;
  logic [5:0]    sel_ctrl;

  logic          do_grant;
  logic          do_capture;
  logic          do_hs;

  // Unpack the flat request buses into per-requester arrays.
  logic [15:0] x_arr    [NREQ];
  logic [15:0] y_arr    [NREQ];
  logic [15:0] z_arr    [NREQ];
  logic [5:0]  ctrl_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign x_arr[gi]    = req_x[gi*16 +: 16];
    assign y_arr[gi]    = req_y[gi*16 +: 16];
    assign z_arr[gi]    = req_z[gi*16 +: 16];
    assign ctrl_arr[gi] = req_ctrl[gi*6 +: 6];
  end

  // Round-robin search: offset k from rr_ptr is visited in increasing order,
  // so the first valid requester at or above the pointer (wrapping) wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sel_x       = x_arr[0];
    sel_y       = y_arr[0];
    sel_z       = z_arr[0];
    sel_ctrl    = ctrl_arr[0];
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_found && req_valid[j] && (((int'(rr_ptr) + k) % NREQ) == j)) begin
          grant_found = 1'b1;
          grant_idx   = 2'(j);
          sel_x       = x_arr[j];
          sel_y       = y_arr[j];
          sel_z       = z_arr[j];
          sel_ctrl    = ctrl_arr[j];
        end
      end
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    do_capture = 1'b0;
    do_hs      = 1'b0;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          do_grant   = 1'b1;
          req_ready  = NREQ'(1) << grant_idx;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          do_capture = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          do_hs      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      rr_ptr        <= '0;
      fma_x         <= '0;
      fma_y         <= '0;
      fma_z         <= '0;
      fma_mul       <= 1'b0;
      fma_add       <= 1'b0;
      fma_negp      <= 1'b0;
      fma_negz      <= 1'b0;
      fma_roundmode <= '0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_flags     <= '0;
      fflags        <= '0;
      op_count      <= '0;
    end else begin
      state <= state_next;

      if (do_grant) begin
        fma_x <= sel_x;
        fma_y <= sel_y;
        fma_z <= sel_z;
        {fma_mul, fma_add, fma_negp, fma_negz, fma_roundmode} <= sel_ctrl;
        rsp_id <= grant_idx;
        cnt    <= CNT_LOAD;
      end else if ((state == EXEC) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      if (do_capture) begin
        rsp_result <= fma_result;
        rsp_flags  <= fma_flags;
      end

      if (do_hs) begin
        op_count <= op_count + 16'd1;
        rr_ptr   <= (rsp_id == 2'(NREQ - 1)) ? 2'd0 : rsp_id + 2'd1;
      end

      // Clear takes effect before the flags of a simultaneous response are merged.
      if (clear_flags) begin
        fflags <= do_hs ? rsp_flags : 4'b0000;
      end else if (do_hs) begin
        fflags <= fflags | rsp_flags;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fma16_issue_ctrl.sv
`timescale 1ns/1ps
// Testbench for fma16_issue_ctrl (NREQ=2, LAT=2).
// A reference model predicts grants, response timing and payload from the
// driven request signals; expected responses are queued at grant time and
// a separate monitor compares them whenever rsp_valid is high.
module tb_fma16_issue_ctrl;

  localparam int NREQ = 2;
  localparam int LAT  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [16*NREQ-1:0] req_x, req_y, req_z;
  logic [6*NREQ-1:0] req_ctrl;
  logic [15:0]       fma_x, fma_y, fma_z;
  logic              fma_mul, fma_add, fma_negp, fma_negz;
  logic [1:0]        fma_roundmode;
  logic [15:0]       fma_result;
  logic [3:0]        fma_flags;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [15:0]       rsp_result;
  logic [3:0]        rsp_flags;
  logic [3:0]        fflags;
  logic              clear_flags;
  logic              busy;
  logic [15:0]       op_count;

  fma16_issue_ctrl #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_ctrl(req_ctrl),
    .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
    .fma_mul(fma_mul), .fma_add(fma_add), .fma_negp(fma_negp), .fma_negz(fma_negz),
    .fma_roundmode(fma_roundmode),
    .fma_result(fma_result), .fma_flags(fma_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .fflags(fflags), .clear_flags(clear_flags),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Stand-in for the fma16 datapath: exact results for the directed operand
  // sets, a deterministic scramble of the inputs otherwise.
  function automatic logic [19:0] fma_ref(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] z, input logic [5:0] c);
    if (x == 16'h3C00 && y == 16'h4000 && z == 16'h0000 && c == 6'b100001) return {4'b0000, 16'h4000};
    if (x == 16'h7BFF && y == 16'h4000 && z == 16'h0000 && c == 6'b100001) return {4'b0101, 16'h7C00};
    if (x == 16'h7BFF && y == 16'h4000 && z == 16'h0000 && c == 6'b100000) return {4'b0101, 16'h7BFF};
    if (x == 16'h3C01 && y == 16'h3C01 && z == 16'h0000 && c == 6'b100001) return {4'b0001, 16'h3C02};
    return {x[3:0] ^ y[7:4] ^ z[11:8] ^ c[3:0], x ^ {y[7:0], y[15:8]} ^ (z + {10'b0, c})};
  endfunction

  assign {fma_flags, fma_result} = fma_ref(fma_x, fma_y, fma_z,
                                           {fma_mul, fma_add, fma_negp, fma_negz, fma_roundmode});

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] res;
    logic [3:0]  fl;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state
  bit          m_busy = 1'b0;
  int          m_tresp = 0;
  int          m_id = 0;
  int          m_ptr = 0;
  logic [15:0] m_x, m_y, m_z;
  logic [5:0]  m_ctrl;
  logic [3:0]  m_fl;
  logic [3:0]  m_fflags = 4'b0;
  logic [15:0] m_count = 16'd0;
  int          grant_cnt [NREQ];
  int          mg;
  bit          mhs;
  logic [19:0] mref;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: expected grants, timing, sticky flags and counter.
  always @(negedge clk) begin
    if (reset) begin
      chk("reset_outs", {4'b0, rsp_valid, rsp_id, rsp_result, rsp_flags, fflags, busy}, 32'd0);
      chk("reset_opcount", {16'd0, op_count}, 32'd0);
      chk("reset_fma_xy", {fma_x, fma_y}, 32'd0);
      chk("reset_fma_zc", {10'd0, fma_z, fma_mul, fma_add, fma_negp, fma_negz, fma_roundmode}, 32'd0);
      m_busy   = 1'b0;
      m_ptr    = 0;
      m_fflags = 4'b0;
      m_count  = 16'd0;
      exp_q.delete();
    end else begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_busy && (cyc >= m_tresp)});
      chk("fflags", {28'd0, fflags}, {28'd0, m_fflags});
      chk("op_count", {16'd0, op_count}, {16'd0, m_count});
      mhs = 1'b0;
      if (!m_busy) begin
        mg = -1;
        for (int k = 0; k < NREQ; k++)
          if (mg < 0 && req_valid[(m_ptr + k) % NREQ]) mg = (m_ptr + k) % NREQ;
        chk("req_ready", {30'd0, req_ready}, (mg < 0) ? 32'd0 : (32'd1 << mg));
        if (mg >= 0) begin
          m_busy  = 1'b1;
          m_tresp = cyc + LAT + 1;
          m_id    = mg;
          m_x     = req_x[mg*16 +: 16];
          m_y     = req_y[mg*16 +: 16];
          m_z     = req_z[mg*16 +: 16];
          m_ctrl  = req_ctrl[mg*6 +: 6];
          mref    = fma_ref(m_x, m_y, m_z, m_ctrl);
          m_fl    = mref[19:16];
          exp_q.push_back('{id: 2'(mg), res: mref[15:0], fl: mref[19:16]});
          grant_cnt[mg]++;
        end
      end else begin
        chk("req_ready_busy", {30'd0, req_ready}, 32'd0);
        chk("fma_xy_hold", {fma_x, fma_y}, {m_x, m_y});
        chk("fma_zc_hold", {10'd0, fma_z, fma_mul, fma_add, fma_negp, fma_negz, fma_roundmode},
            {10'd0, m_z, m_ctrl});
        if (cyc >= m_tresp && rsp_ready) mhs = 1'b1;
      end
      if (clear_flags) m_fflags = 4'b0;
      if (mhs) begin
        m_fflags = m_fflags | m_fl;
        m_count  = m_count + 16'd1;
        m_ptr    = (m_id + 1) % NREQ;
        m_busy   = 1'b0;
      end
    end
  end

  // Monitor: compares the presented response with the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        chk("rsp_id", {30'd0, rsp_id}, {30'd0, exp_q[0].id});
        chk("rsp_result", {16'd0, rsp_result}, {16'd0, exp_q[0].res});
        chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, exp_q[0].fl});
        if (rsp_ready) begin
          $display("rsp cycle=%0d id=%0d result=0x%04h flags=%04b", cyc, rsp_id, rsp_result, rsp_flags);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z, input logic [5:0] c);
    req_x[i*16 +: 16] = x;
    req_y[i*16 +: 16] = y;
    req_z[i*16 +: 16] = z;
    req_ctrl[i*6 +: 6] = c;
  endtask

  task automatic new_op(input int i);
    set_op(i, 16'($urandom), 16'($urandom), 16'($urandom), 6'($urandom));
  endtask

  // Raise req_valid[i] with the given op, wait for its grant, then drop it.
  task automatic issue(input int i, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] z, input logic [5:0] c);
    int g0;
    g0 = grant_cnt[i];
    set_op(i, x, y, z, c);
    req_valid[i] = 1'b1;
    for (int t = 0; t < 60 && grant_cnt[i] == g0; t++) step();
    chk("grant_wait", 32'(grant_cnt[i] - g0), 32'd1);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 100 && (m_busy || exp_q.size() != 0); t++) step();
    chk("idle_wait", {31'd0, m_busy}, 32'd0);
  endtask

  int seen [NREQ];
  int tot0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_x = '0; req_y = '0; req_z = '0; req_ctrl = '0;
    rsp_ready = 1'b0;
    clear_flags = 1'b0;
    for (int i = 0; i < NREQ; i++) grant_cnt[i] = 0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Single multiply, rne
    rsp_ready = 1'b1;
    issue(0, 16'h3C00, 16'h4000, 16'h0000, 6'b100001);
    wait_idle();
    step();
    chk("t1_op_count", {16'd0, op_count}, 32'd1);

    // Two requesters valid continuously: grants must alternate
    for (int i = 0; i < NREQ; i++) begin new_op(i); seen[i] = grant_cnt[i]; req_valid[i] = 1'b1; end
    tot0 = grant_cnt[0] + grant_cnt[1];
    for (int t = 0; t < 100 && (grant_cnt[0] + grant_cnt[1]) < tot0 + 4; t++) begin
      step();
      for (int i = 0; i < NREQ; i++)
        if (grant_cnt[i] != seen[i]) begin new_op(i); seen[i] = grant_cnt[i]; end
    end
    chk("t2_grants", 32'(grant_cnt[0] + grant_cnt[1] - tot0), 32'd4);
    req_valid = '0;
    wait_idle();

    // Overflow with rne and rz
    clear_flags = 1'b1; step(); clear_flags = 1'b0;
    issue(1, 16'h7BFF, 16'h4000, 16'h0000, 6'b100001);
    wait_idle();
    issue(1, 16'h7BFF, 16'h4000, 16'h0000, 6'b100000);
    wait_idle();
    step();
    chk("t3_fflags", {28'd0, fflags}, 32'h5);

    // Consumer stall: response held, no new grant
    rsp_ready = 1'b0;
    issue(0, 16'h1234, 16'h5678, 16'h9ABC, 6'b110010);
    new_op(1);
    req_valid[1] = 1'b1;
    for (int t = 0; t < 20 && !rsp_valid; t++) step();
    chk("t4_rsp_wait", {31'd0, rsp_valid}, 32'd1);
    repeat (5) step();
    rsp_ready = 1'b1;
    seen[1] = grant_cnt[1];
    for (int t = 0; t < 20 && grant_cnt[1] == seen[1]; t++) step();
    req_valid[1] = 1'b0;
    wait_idle();

    // clear_flags coinciding with an inexact response, then alone
    rsp_ready = 1'b0;
    issue(0, 16'h3C01, 16'h3C01, 16'h0000, 6'b100001);
    for (int t = 0; t < 20 && !rsp_valid; t++) step();
    chk("t5_rsp_wait", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    step();
    chk("t5_fflags_merge", {28'd0, fflags}, 32'h1);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    step();
    chk("t5_fflags_clear", {28'd0, fflags}, 32'h0);

    // Reset during EXEC with rr_ptr pointing at requester 1
    issue(0, 16'h1111, 16'h2222, 16'h3333, 6'b100011);
    wait_idle();
    issue(0, 16'h4444, 16'h5555, 16'h6666, 6'b010001);
    reset = 1'b1;
    req_valid = '0;
    repeat (2) step();
    reset = 1'b0;
    new_op(0); new_op(1);
    seen[0] = grant_cnt[0];
    seen[1] = grant_cnt[1];
    req_valid = 2'b11;
    for (int t = 0; t < 20 && grant_cnt[0] == seen[0] && grant_cnt[1] == seen[1]; t++) step();
    chk("t6_first_grant", 32'(grant_cnt[0] - seen[0]), 32'd1);
    req_valid[0] = 1'b0;
    for (int t = 0; t < 20 && grant_cnt[1] == seen[1]; t++) step();
    req_valid = '0;
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < NREQ; i++) seen[i] = grant_cnt[i];
    for (int t = 0; t < 500; t++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (grant_cnt[i] != seen[i]) begin
          seen[i] = grant_cnt[i];
          new_op(i);
          req_valid[i] = ($urandom % 4) != 0;
        end else if (!req_valid[i]) begin
          new_op(i);
          req_valid[i] = ($urandom % 3) == 0;
        end else if (($urandom % 10) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready   = ($urandom % 3) != 0;
      clear_flags = ($urandom % 16) == 0;
    end
    req_valid = '0;
    clear_flags = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
